// File: rtl/mvu_pkg.sv
// Shared state encoding, default parameters and the term tag that travels
// down the read-latency pipe of the matrix-vector unit.
package mvu_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  localparam int N_DEF   = 64;
  localparam int W_DEF   = 32;
  localparam int AW_DEF  = 9;
  localparam int PW_DEF  = 4;
  localparam int TW_DEF  = 8;
  localparam int LAT_DEF = 2;

  typedef struct packed {
    logic vld;
    logic first;
    logic newk;
    logic neg;
  } tag_t;

endpackage

// File: rtl/mvu_seq_if.sv
// Job, RAM-read and result signals of the matrix-vector unit back end.
interface mvu_seq_if
  import mvu_pkg::*;
#(
  parameter int N  = N_DEF,
  parameter int W  = W_DEF,
  parameter int SW = $clog2(N) + 2,
  parameter int AW = AW_DEF,
  parameter int PW = PW_DEF,
  parameter int TW = TW_DEF
) ();
  // Handshake: start is a request sampled only while busy=0; there is no ready.
  // rd_en has no back-pressure and S must hold the matching sums exactly LAT
  // cycles after each rd_en; o_valid and err are single-cycle pulses.
  logic              start;
  logic [PW-1:0]     wprec;
  logic [PW-1:0]     aprec;
  logic              wsigned;
  logic              asigned;
  logic [TW-1:0]     tiles;
  logic [AW-1:0]     wbase;
  logic [AW-1:0]     abase;
  logic              rd_en;
  logic [AW-1:0]     waddr;
  logic [AW-1:0]     aaddr;
  logic [N*SW-1:0]   S;
  logic [N*W-1:0]    O;
  logic              o_valid;
  logic              busy;
  logic              err;

  modport master (
    output start, wprec, aprec, wsigned, asigned, tiles, wbase, abase, S,
    input  rd_en, waddr, aaddr, O, o_valid, busy, err
  );

  modport slave (
    input  start, wprec, aprec, wsigned, asigned, tiles, wbase, abase, S,
    output rd_en, waddr, aaddr, O, o_valid, busy, err
  );
endinterface

// File: rtl/mvu_lane_acc.sv
// One lane of the result vector: sign-extends the lane partial sum, optionally
// negates it, and adds it to the accumulator (doubled on a new significance).
module mvu_lane_acc #(
  parameter int W  = 32,
  parameter int SW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  input  logic          first,
  input  logic          newk,
  input  logic          neg,
  input  logic [SW-1:0] s,
  output logic [W-1:0]  acc_o
);
  logic [W-1:0] acc_q, acc_d;
  logic [W-1:0] s_ext, s_term, base;

  always_comb begin
    s_ext  = W'($signed(s));
    s_term = neg ? -s_ext : s_ext;
    base   = first ? '0 : (newk ? {acc_q[W-2:0], 1'b0} : acc_q);
    acc_d  = en ? base + s_term : acc_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) acc_q <= '0;
    else        acc_q <= acc_d;
  end

  assign acc_o = acc_q;
endmodule

// File: rtl/mvu_seq.sv
// Bit-serial MVU back end: walks every weight/activation bit-plane pair and tile,
// issues RAM reads, and shift-accumulates the returned lane partial sums.
module mvu_seq
  import mvu_pkg::*;
#(
  parameter int N   = N_DEF,
  parameter int W   = W_DEF,
  parameter int SW  = $clog2(N) + 2,
  parameter int AW  = AW_DEF,
  parameter int PW  = PW_DEF,
  parameter int TW  = TW_DEF,
  parameter int LAT = LAT_DEF
) (
  input  logic     clk,
  input  logic     rst_n,
  mvu_seq_if.slave bus,
  output state_e   state_o
);
  localparam int KW = PW + 1;
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  state_e        state_q, state_d;
  logic [KW-1:0] k_q, k_d;
  logic [PW-1:0] i_q, i_d;
  logic [TW-1:0] t_q, t_d;
  logic [CW-1:0] dcnt_q, dcnt_d;
  logic          first_q, first_d, newk_q, newk_d;
  logic          accept, reject, err_q;

  logic [PW-1:0] wprec_q, aprec_q;
  logic          wsigned_q, asigned_q;
  logic [TW-1:0] tiles_q;
  logic [AW-1:0] wbase_q, abase_q;

  logic [KW-1:0] wpm1_w, apm1_w, j_w, i_lo, km1;
  logic          neg;

  // Valid i range for the current significance k is [i_lo, min(k, wprec-1)].
  assign wpm1_w = KW'(wprec_q) - KW'(1);
  assign apm1_w = KW'(aprec_q) - KW'(1);
  assign j_w    = k_q - KW'(i_q);
  assign i_lo   = (k_q > apm1_w) ? k_q - apm1_w : '0;
  assign km1    = k_q - KW'(1);
  assign neg    = (wsigned_q && (KW'(i_q) == wpm1_w)) ^ (asigned_q && (j_w == apm1_w));

  always_comb begin
    state_d = state_q;
    k_d     = k_q;
    i_d     = i_q;
    t_d     = t_q;
    dcnt_d  = dcnt_q;
    first_d = first_q;
    newk_d  = newk_q;
    accept  = 1'b0;
    reject  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          if (bus.wprec != '0 && bus.aprec != '0 && bus.tiles != '0) begin
            accept  = 1'b1;
            state_d = ST_RUN;
            k_d     = KW'(bus.wprec) + KW'(bus.aprec) - KW'(2);
            i_d     = bus.wprec - PW'(1);
            t_d     = '0;
            first_d = 1'b1;
            newk_d  = 1'b0;
          end else begin
            reject = 1'b1;
          end
        end
      end
      ST_RUN: begin
        first_d = 1'b0;
        newk_d  = 1'b0;
        if (t_q != tiles_q - TW'(1)) begin
          t_d = t_q + TW'(1);
        end else begin
          t_d = '0;
          if (KW'(i_q) != i_lo) begin
            i_d = i_q - PW'(1);
          end else if (k_q == '0) begin
            state_d = ST_DRAIN;
            dcnt_d  = '0;
          end else begin
            k_d    = km1;
            i_d    = (km1 < wpm1_w) ? km1[PW-1:0] : wpm1_w[PW-1:0];
            newk_d = 1'b1;
          end
        end
      end
      ST_DRAIN: begin
        if (dcnt_q == CW'(LAT - 1)) state_d = ST_DONE;
        else                        dcnt_d  = dcnt_q + CW'(1);
      end
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      k_q     <= '0;
      i_q     <= '0;
      t_q     <= '0;
      dcnt_q  <= '0;
      first_q <= 1'b0;
      newk_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      i_q     <= i_d;
      t_q     <= t_d;
      dcnt_q  <= dcnt_d;
      first_q <= first_d;
      newk_q  <= newk_d;
      err_q   <= reject;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wprec_q   <= '0;
      aprec_q   <= '0;
      wsigned_q <= 1'b0;
      asigned_q <= 1'b0;
      tiles_q   <= '0;
      wbase_q   <= '0;
      abase_q   <= '0;
    end else if (accept) begin
      wprec_q   <= bus.wprec;
      aprec_q   <= bus.aprec;
      wsigned_q <= bus.wsigned;
      asigned_q <= bus.asigned;
      tiles_q   <= bus.tiles;
      wbase_q   <= bus.wbase;
      abase_q   <= bus.abase;
    end
  end

  // Tags ride an LAT-deep pipe so they meet S in the same cycle.
  tag_t cur_tag;
  tag_t pipe_q [LAT];

  always_comb begin
    cur_tag = '0;
    if (state_q == ST_RUN) begin
      cur_tag.vld   = 1'b1;
      cur_tag.first = first_q;
      cur_tag.newk  = newk_q;
      cur_tag.neg   = neg;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int s = 0; s < LAT; s++) pipe_q[s] <= '0;
    end else begin
      pipe_q[0] <= cur_tag;
      for (int s = 1; s < LAT; s++) pipe_q[s] <= pipe_q[s-1];
    end
  end

  logic [N*W-1:0] o_flat;

  for (genvar g = 0; g < N; g++) begin : g_lane
    mvu_lane_acc #(.W(W), .SW(SW)) u_acc (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (pipe_q[LAT-1].vld),
      .first (pipe_q[LAT-1].first),
      .newk  (pipe_q[LAT-1].newk),
      .neg   (pipe_q[LAT-1].neg),
      .s     (bus.S[g*SW +: SW]),
      .acc_o (o_flat[g*W +: W])
    );
  end

  assign bus.rd_en   = (state_q == ST_RUN);
  assign bus.waddr   = wbase_q + AW'(32'(i_q) * 32'(tiles_q) + 32'(t_q));
  assign bus.aaddr   = abase_q + AW'(32'(j_w) * 32'(tiles_q) + 32'(t_q));
  assign bus.O       = o_flat;
  assign bus.o_valid = (state_q == ST_DONE);
  assign bus.busy    = (state_q != ST_IDLE);
  assign bus.err     = err_q;
  assign state_o     = state_q;
endmodule

// File: tb/tb_mvu_seq.sv
// Bench for mvu_seq: two instances (W=32 with narrow S, W=8 with wide S) run the
// same jobs; results are predicted as a plain signed weighted sum over all terms.
module tb_mvu_seq;
  import mvu_pkg::*;

  localparam int NL  = 4;
  localparam int LAT = LAT_DEF;
  localparam int AW  = AW_DEF;
  localparam int PW  = PW_DEF;
  localparam int TW  = TW_DEF;
  localparam int WA  = 32;
  localparam int SWA = $clog2(NL) + 2;
  localparam int WB  = 8;
  localparam int SWB = 8;
  localparam int SAW = NL * SWA;
  localparam int SBW = NL * SWB;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_r;
  logic [PW-1:0] wprec_r, aprec_r;
  logic          ws_r, as_r;
  logic [TW-1:0] tiles_r;
  logic [AW-1:0] wbase_r, abase_r;
  logic [SAW-1:0] s_a;
  logic [SBW-1:0] s_b;
  state_e st_a, st_b;

  mvu_seq_if #(.N(NL), .W(WA), .SW(SWA), .AW(AW), .PW(PW), .TW(TW)) bus_a ();
  mvu_seq_if #(.N(NL), .W(WB), .SW(SWB), .AW(AW), .PW(PW), .TW(TW)) bus_b ();

  assign bus_a.start = start_r;   assign bus_b.start = start_r;
  assign bus_a.wprec = wprec_r;   assign bus_b.wprec = wprec_r;
  assign bus_a.aprec = aprec_r;   assign bus_b.aprec = aprec_r;
  assign bus_a.wsigned = ws_r;    assign bus_b.wsigned = ws_r;
  assign bus_a.asigned = as_r;    assign bus_b.asigned = as_r;
  assign bus_a.tiles = tiles_r;   assign bus_b.tiles = tiles_r;
  assign bus_a.wbase = wbase_r;   assign bus_b.wbase = wbase_r;
  assign bus_a.abase = abase_r;   assign bus_b.abase = abase_r;
  assign bus_a.S = s_a;           assign bus_b.S = s_b;

  mvu_seq #(.N(NL), .W(WA), .SW(SWA), .AW(AW), .PW(PW), .TW(TW), .LAT(LAT)) dut_a (
    .clk(clk), .rst_n(rst_n), .bus(bus_a), .state_o(st_a));
  mvu_seq #(.N(NL), .W(WB), .SW(SWB), .AW(AW), .PW(PW), .TW(TW), .LAT(LAT)) dut_b (
    .clk(clk), .rst_n(rst_n), .bus(bus_b), .state_o(st_b));

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [2*AW-1:0] exp_q[$];
  logic [SAW-1:0]  sq_a[$];
  logic [SBW-1:0]  sq_b[$];
  bit              rd_hist[$];

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Array model: answers each read LAT cycles later with the queued partial sums.
  always @(negedge clk) begin
    if (!rst_n) begin
      rd_hist.delete();
    end else begin
      rd_hist.push_back(bus_a.rd_en);
      if (rd_hist.size() > LAT) begin
        if (rd_hist.pop_front()) begin
          check("s_avail", 64'(sq_a.size() != 0), 64'd1);
          if (sq_a.size() != 0) begin
            s_a = sq_a.pop_front();
            s_b = sq_b.pop_front();
          end
        end else begin
          s_a = SAW'($urandom);
          s_b = SBW'($urandom);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic scramble_fields();
    wprec_r = PW'($urandom);  aprec_r = PW'($urandom);
    ws_r    = 1'($urandom);   as_r    = 1'($urandom);
    tiles_r = TW'($urandom);  wbase_r = AW'($urandom); abase_r = AW'($urandom);
  endtask

  // smode: 0 random S, 1 lane0 = term index + 1, 2 every lane at its max positive value.
  task automatic run_job(input int wp, input int ap, input bit ws, input bit as_, input int tl,
                         input int wb, input int ab, input int smode,
                         input int abort_at, input int poke_at);
    longint sum_a[NL], sum_b[NL];
    longint sg;
    int tt, last, idx, j, va, vb;
    bit negb;
    logic [SAW-1:0] pa;
    logic [SBW-1:0] pb;
    logic [2*AW-1:0] ead;
    logic [WA-1:0] ea;
    logic [WB-1:0] eb;
    tt = wp * ap * tl; last = tt + LAT + 1; idx = 0;
    pa = '0; pb = '0;
    for (int l = 0; l < NL; l++) begin sum_a[l] = 0; sum_b[l] = 0; end
    for (int k = wp + ap - 2; k >= 0; k--) begin
      for (int i = wp - 1; i >= 0; i--) begin
        j = k - i;
        if (j >= 0 && j < ap) begin
          for (int t = 0; t < tl; t++) begin
            negb = (ws && i == wp - 1) != (as_ && j == ap - 1);
            sg = negb ? -1 : 1;
            exp_q.push_back({AW'(wb + i * tl + t), AW'(ab + j * tl + t)});
            for (int l = 0; l < NL; l++) begin
              va = int'($urandom_range(15, 0)) - 8;
              vb = int'($urandom_range(255, 0)) - 128;
              if (smode == 1 && l == 0) begin va = idx + 1; vb = idx + 1; end
              if (smode == 2) begin va = 7; vb = 127; end
              pa[l*SWA +: SWA] = SWA'(va);
              pb[l*SWB +: SWB] = SWB'(vb);
              sum_a[l] += sg * longint'(va) * (longint'(1) << k);
              sum_b[l] += sg * longint'(vb) * (longint'(1) << k);
            end
            sq_a.push_back(pa); sq_b.push_back(pb);
            idx++;
          end
        end
      end
    end

    @(negedge clk);
    check("idle_busy", {bus_a.busy, bus_b.busy}, 0);
    check("idle_valid", {bus_a.o_valid, bus_b.o_valid}, 0);
    start_r = 1'b1;
    wprec_r = PW'(wp); aprec_r = PW'(ap); ws_r = ws; as_r = as_;
    tiles_r = TW'(tl); wbase_r = AW'(wb); abase_r = AW'(ab);
    for (int n = 1; n <= last; n++) begin
      @(negedge clk);
      start_r = (n == poke_at);
      scramble_fields();
      if (n == abort_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_o", {|bus_a.O, |bus_b.O}, 0);
        check("abort_busy", {bus_a.busy, bus_b.busy}, 0);
        check("abort_valid", {bus_a.o_valid, bus_b.o_valid, bus_a.rd_en}, 0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        start_r = 1'b0;
        exp_q.delete(); sq_a.delete(); sq_b.delete();
        break;
      end
      check("rd_en", {bus_a.rd_en, bus_b.rd_en}, {2{n <= tt}});
      check("busy", {bus_a.busy, bus_b.busy}, 2'b11);
      check("o_valid", {bus_a.o_valid, bus_b.o_valid}, {2{n == last}});
      check("err", {bus_a.err, bus_b.err}, 0);
      if (bus_a.rd_en && exp_q.size() != 0) begin
        ead = exp_q.pop_front();
        check("addr_a", {bus_a.waddr, bus_a.aaddr}, ead);
        check("addr_b", {bus_b.waddr, bus_b.aaddr}, ead);
      end
      if (n == last) begin
        for (int l = 0; l < NL; l++) begin
          ea = WA'(sum_a[l]);
          eb = WB'(sum_b[l]);
          check($sformatf("o_a[%0d]", l), bus_a.O[l*WA +: WA], ea);
          check($sformatf("o_b[%0d]", l), bus_b.O[l*WB +: WB], eb);
        end
        check("scb_left", exp_q.size() + sq_a.size(), 0);
      end
    end
    start_r = 1'b0;
  endtask

  task automatic try_reject(input int wp, input int ap, input int tl);
    int errs, rds, bz;
    errs = 0; rds = 0; bz = 0;
    @(negedge clk);
    start_r = 1'b1;
    wprec_r = PW'(wp); aprec_r = PW'(ap); tiles_r = TW'(tl);
    #1;
    errs += int'(bus_a.err) + int'(bus_b.err);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      start_r = 1'b0;
      errs += int'(bus_a.err) + int'(bus_b.err);
      rds  += int'(bus_a.rd_en) + int'(bus_b.rd_en);
      bz   += int'(bus_a.busy) + int'(bus_b.busy);
    end
    check("rej_err", errs, 2);
    check("rej_rd", rds, 0);
    check("rej_busy", bz, 0);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    start_r = 1'b0; wprec_r = '0; aprec_r = '0; ws_r = 1'b0; as_r = 1'b0;
    tiles_r = '0; wbase_r = '0; abase_r = '0; s_a = '0; s_b = '0;
    repeat (3) @(negedge clk);
    check("rst_rd", {bus_a.rd_en, bus_b.rd_en}, 0);
    check("rst_busy", {bus_a.busy, bus_b.busy}, 0);
    check("rst_valid_err", {bus_a.o_valid, bus_b.o_valid, bus_a.err, bus_b.err}, 0);
    check("rst_o", {|bus_a.O, |bus_b.O}, 0);
    check("rst_state", {st_a, st_b}, {ST_IDLE, ST_IDLE});
    rst_n = 1'b1;

    run_job(2, 2, 0, 0, 1, 0, 0, 1, 0, 0);
    check("t1_lane0_a", bus_a.O[WA-1:0], 18);
    check("t1_lane0_b", bus_b.O[WB-1:0], 18);

    run_job(2, 2, 1, 1, 1, 5, 9, 1, 0, 0);
    check("t2_lane0_a", bus_a.O[WA-1:0], 32'hFFFF_FFFE);
    check("t2_lane0_b", bus_b.O[WB-1:0], 8'hFE);

    run_job(1, 1, 0, 0, 3, 10, 20, 0, 0, 0);

    try_reject(2, 2, 0);
    try_reject(0, 3, 1);
    try_reject(3, 0, 2);
    run_job(3, 2, 1, 0, 2, 100, 200, 0, 0, 2);

    run_job(2, 2, 0, 0, 1, 0, 0, 1, 2, 0);
    run_job(2, 2, 0, 0, 1, 0, 0, 1, 0, 0);
    check("t5_lane0_a", bus_a.O[WA-1:0], 18);

    run_job(4, 4, 0, 0, 1, 30, 40, 2, 0, 0);
    check("t6_lane0_b", bus_b.O[WB-1:0], 159);
    check("t6_lane0_a", bus_a.O[WA-1:0], 1575);
    run_job(3, 3, 1, 1, 2, 500, 505, 0, 0, 0);

    run_job(15, 15, 1, 1, 1, 500, 7, 0, 0, 0);
    run_job(1, 1, 1, 1, 255, 400, 300, 0, 0, 0);
    run_job(15, 1, 1, 0, 2, 511, 0, 0, 0, 0);

    for (int r = 0; r < 20; r++) begin
      repeat ($urandom_range(2, 0)) @(negedge clk);
      run_job($urandom_range(6, 1), $urandom_range(6, 1),
              $urandom_range(1, 0) == 1, $urandom_range(1, 0) == 1,
              $urandom_range(4, 1), $urandom_range(511, 0), $urandom_range(511, 0),
              0, 0, ($urandom_range(3, 0) == 0) ? 2 : 0);
    end

    @(negedge clk);
    check("end_busy", {bus_a.busy, bus_b.busy}, 0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
